// File: rtl/t9990_palette_arb_pkg.sv
// T9990 palette arbiter package: palette entry layout, CPU byte-lane codes,
// FSM state encoding and the lane encode/decode helpers.
package t9990_palette_arb_pkg;

  // One palette word as stored in RAM: {Ys, G5, R5, B5}
  typedef struct packed {
    logic       ys;
    logic [4:0] g;
    logic [4:0] r;
    logic [4:0] b;
  } pal_entry_t;

  // Byte lane selected by CPU_ADDR[1:0]
  localparam logic [1:0] PAL_LANE_R     = 2'd0;
  localparam logic [1:0] PAL_LANE_G     = 2'd1;
  localparam logic [1:0] PAL_LANE_B     = 2'd2;
  localparam logic [1:0] PAL_LANE_DUMMY = 2'd3;

  // CPU access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RDCAP  = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;

  // Bit-enable mask for a byte-lane write; the R lane also carries Ys
  function automatic logic [15:0] pal_wmask(input logic [1:0] lane);
    logic [15:0] mask;
    case (lane)
      PAL_LANE_R: mask = 16'h83E0;
      PAL_LANE_G: mask = 16'h7C00;
      PAL_LANE_B: mask = 16'h001F;
      default:    mask = 16'h0000;
    endcase
    return mask;
  endfunction

  // Replicate the 5-bit level into every field; the mask picks the live one
  function automatic logic [15:0] pal_wdata(input logic [7:0] wbyte);
    return {wbyte[7], wbyte[4:0], wbyte[4:0], wbyte[4:0]};
  endfunction

  // Byte returned to the CPU for a given lane of a palette word
  function automatic logic [7:0] pal_rbyte(input pal_entry_t e, input logic [1:0] lane);
    logic [7:0] rb;
    case (lane)
      PAL_LANE_R: rb = {e.ys, 2'b00, e.r};
      PAL_LANE_G: rb = {3'b000, e.g};
      PAL_LANE_B: rb = {3'b000, e.b};
      default:    rb = 8'h00;
    endcase
    return rb;
  endfunction

endpackage

// File: rtl/t9990_palette_arb_if.sv
// T9990 palette arbiter CPU-side handshake: P#1 port logic (master) issues a
// level request held until a one-CLK acknowledge from the arbiter (slave).
interface t9990_palette_arb_if;
  logic       CPU_REQ;
  logic       CPU_WE;
  logic [7:0] CPU_ADDR;
  logic [7:0] CPU_WDATA;
  logic       CPU_ACK;
  logic [7:0] CPU_RDATA;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  CPU_ACK, CPU_RDATA
  );

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output CPU_ACK, CPU_RDATA
  );
endinterface

// File: rtl/t9990_palette_arb_ram.sv
// T9990 palette RAM: 64 x 16 single-port synchronous RAM with per-bit write
// enable and 1-CLK read latency. The single read port lands in one of two
// output registers (display or CPU) so a CPU read never disturbs the colour
// currently being shown. Array contents are not reset.
module t9990_pal_ram (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [5:0]  addr,
  input  logic        we,
  input  logic [15:0] wmask,
  input  logic [15:0] wdata,
  input  logic        disp_re,
  input  logic        cpu_re,
  output logic [15:0] disp_q,
  output logic [15:0] cpu_q
);

  logic [15:0] mem_r [0:63];
  logic [15:0] disp_q_r;
  logic [15:0] cpu_q_r;

  // Bit-masked write: only enabled bits change, no read-modify-write
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 16; i++) begin
        if (wmask[i]) begin
          mem_r[addr][i] <= wdata[i];
        end
      end
    end
  end

  // Display read register: holds the last looked-up colour between slots
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      disp_q_r <= 16'h0000;
    end else if (disp_re) begin
      disp_q_r <= mem_r[addr];
    end
  end

  // CPU read register: loaded only by a granted CPU read
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cpu_q_r <= 16'h0000;
    end else if (cpu_re) begin
      cpu_q_r <= mem_r[addr];
    end
  end

  assign disp_q = disp_q_r;
  assign cpu_q  = cpu_q_r;

endmodule

// File: rtl/t9990_palette_arb.sv
// T9990 palette arbiter top: shares the palette RAM port between display
// lookup (wins every slot) and CPU P#1 byte accesses (REQ/ACK handshake).
// Optional build macro T9990_PAL_STEAL_EN: a CPU access blocked for
// STEAL_LIMIT cycles takes the next display slot and pulses STEAL.
module t9990_palette_arb
  import t9990_palette_arb_pkg::*;
#(
  parameter int STEAL_LIMIT = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic                      DCLK_EN,
  input  logic                      DISP_ACTIVE,
  input  logic [5:0]                DISP_PA,
  output logic [15:0]               DISP_CLR,
  t9990_palette_arb_if.slave        cpu,
  output logic                      STEAL
);

  localparam int              CW      = $clog2(STEAL_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(STEAL_LIMIT);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);

  arb_state_t    state_r, state_nx_s;

  logic          we_r;
  logic [5:0]    entry_r;
  logic [1:0]    lane_r;
  logic [7:0]    wbyte_r;
  logic [CW-1:0] wait_cnt_r;

  logic          ack_r;
  logic [7:0]    rdata_r;
  logic          steal_r;

  logic          slot_s;
  logic          dummy_s;
  logic          at_limit_s;
  logic          steal_s;
  logic          grant_s;
  logic          blocked_s;

  logic [5:0]    ram_addr_s;
  logic          ram_we_s;
  logic          ram_cpu_re_s;
  logic          ram_disp_re_s;
  logic [15:0]   ram_wmask_s;
  logic [15:0]   ram_wdata_s;
  logic          ack_s;
  logic          rdata_ld_s;
  logic [15:0]   cpu_q_s;
  logic [15:0]   disp_q_s;

  // Arbitration: the display owns every slot unless the CPU is allowed to steal.
  // A dummy-lane access never touches the port, so it never waits or steals.
  assign slot_s     = DCLK_EN & DISP_ACTIVE;
  assign dummy_s    = (lane_r == PAL_LANE_DUMMY);
  assign at_limit_s = (wait_cnt_r == LIMIT_C);

`ifdef T9990_PAL_STEAL_EN
  assign steal_s = (state_r == ST_LATCH) && !dummy_s && slot_s && at_limit_s;
`else
  assign steal_s = 1'b0;
`endif

  assign grant_s   = (state_r == ST_LATCH) && !dummy_s && (!slot_s || steal_s);
  assign blocked_s = (state_r == ST_LATCH) && !dummy_s && slot_s && !steal_s;

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state: the RAM operation happens in the granted LATCH cycle,
  // ACCESS completes it, reads spend one more cycle moving data to CPU_RDATA
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu.CPU_REQ) begin
          state_nx_s = ST_LATCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (dummy_s || grant_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_LATCH;
        end
      end
      ST_ACCESS: begin
        if (we_r) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RDCAP;
        end
      end
      ST_RDCAP: state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: RAM port steering and next-cycle handshake strobes
  always_comb begin
    ram_addr_s    = DISP_PA;
    ram_we_s      = 1'b0;
    ram_cpu_re_s  = 1'b0;
    ram_disp_re_s = 1'b0;
    ram_wmask_s   = pal_wmask(lane_r);
    ram_wdata_s   = pal_wdata(wbyte_r);
    ack_s         = (state_nx_s == ST_DONE);
    rdata_ld_s    = (state_r == ST_RDCAP);
    if (grant_s) begin
      ram_addr_s   = entry_r;
      ram_we_s     = we_r;
      ram_cpu_re_s = !we_r;
    end else begin
      ram_disp_re_s = slot_s;
    end
  end

  // Request capture: later changes on the bus are ignored until the next IDLE
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      we_r    <= 1'b0;
      entry_r <= 6'd0;
      lane_r  <= 2'd0;
      wbyte_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && cpu.CPU_REQ) begin
      we_r    <= cpu.CPU_WE;
      entry_r <= cpu.CPU_ADDR[7:2];
      lane_r  <= cpu.CPU_ADDR[1:0];
      wbyte_r <= cpu.CPU_WDATA;
    end
  end

  // Wait counter: counts blocked cycles, saturates at the limit, cleared on access
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if (state_nx_s == ST_ACCESS) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if (blocked_s && !at_limit_s) begin
      wait_cnt_r <= wait_cnt_r + ONE_C;
    end
  end

  // Handshake output registers; CPU_RDATA changes only on read completions
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
      steal_r <= 1'b0;
    end else begin
      ack_r   <= ack_s;
      steal_r <= steal_s;
      if (rdata_ld_s) begin
        rdata_r <= pal_rbyte(pal_entry_t'(cpu_q_s), lane_r);
      end
    end
  end

  t9990_pal_ram u_ram (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .addr    (ram_addr_s),
    .we      (ram_we_s),
    .wmask   (ram_wmask_s),
    .wdata   (ram_wdata_s),
    .disp_re (ram_disp_re_s),
    .cpu_re  (ram_cpu_re_s),
    .disp_q  (disp_q_s),
    .cpu_q   (cpu_q_s)
  );

  assign DISP_CLR      = disp_q_s;
  assign cpu.CPU_ACK   = ack_r;
  assign cpu.CPU_RDATA = rdata_r;
  assign STEAL         = steal_r;

endmodule

// File: tb/tb_t9990_palette_arb.sv
// Directed bench for t9990_palette_arb with hand-computed expected values.
// Build with +define+T9990_PAL_STEAL_EN to exercise the slot-steal path.
module tb_t9990_palette_arb;

  logic        CLK;
  logic        RESET_n;
  logic        DCLK_EN;
  logic        DISP_ACTIVE;
  logic [5:0]  DISP_PA;
  logic [15:0] DISP_CLR;
  logic        STEAL;

  t9990_palette_arb_if cpu_bus ();

  t9990_palette_arb #(.STEAL_LIMIT(4)) dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .DCLK_EN     (DCLK_EN),
    .DISP_ACTIVE (DISP_ACTIVE),
    .DISP_PA     (DISP_PA),
    .DISP_CLR    (DISP_CLR),
    .cpu         (cpu_bus),
    .STEAL       (STEAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One CPU access; returns read byte and number of edges from REQ to ACK
  task automatic cpu_xfer(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
    cpu_bus.CPU_REQ   = 1'b1;
    cpu_bus.CPU_WE    = we;
    cpu_bus.CPU_ADDR  = addr;
    cpu_bus.CPU_WDATA = wd;
    lat = 0;
    rd  = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (cpu_bus.CPU_ACK) begin
        rd = cpu_bus.CPU_RDATA;
        break;
      end
    end
    cpu_bus.CPU_REQ = 1'b0;
    tick();
    check_vec("ack_one_clk", 32'(cpu_bus.CPU_ACK), 32'h0);
  endtask

  // Display one dot of entry pa and check the looked-up colour
  task automatic disp_dot(input logic [5:0] pa, input logic [15:0] exp, input string tag);
    DCLK_EN     = 1'b1;
    DISP_ACTIVE = 1'b1;
    DISP_PA     = pa;
    tick();
    DCLK_EN     = 1'b0;
    DISP_ACTIVE = 1'b0;
    check_vec(tag, 32'(DISP_CLR), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         lat;
    int         acks;
    int         steals;

    RESET_n           = 1'b0;
    DCLK_EN           = 1'b0;
    DISP_ACTIVE       = 1'b0;
    DISP_PA           = 6'd0;
    cpu_bus.CPU_REQ   = 1'b0;
    cpu_bus.CPU_WE    = 1'b0;
    cpu_bus.CPU_ADDR  = 8'h00;
    cpu_bus.CPU_WDATA = 8'h00;
    repeat (2) tick();
    RESET_n = 1'b1;
    tick();
    check_vec("rst_disp_clr", 32'(DISP_CLR), 32'h0);
    check_vec("rst_ack", 32'(cpu_bus.CPU_ACK), 32'h0);
    check_vec("rst_rdata", 32'(cpu_bus.CPU_RDATA), 32'h0);
    check_vec("rst_steal", 32'(STEAL), 32'h0);

    // Test 1: entry 5 = {Ys=1, G=00, R=1F, B=0A} written during blanking
    cpu_xfer(1'b1, 8'h14, 8'h9F, rd, lat);
    check_vec("wr_r_lat", 32'(lat), 32'd3);
    cpu_xfer(1'b1, 8'h15, 8'h00, rd, lat);
    check_vec("wr_g_lat", 32'(lat), 32'd3);
    cpu_xfer(1'b1, 8'h16, 8'h0A, rd, lat);
    check_vec("wr_b_lat", 32'(lat), 32'd3);
    disp_dot(6'd5, 16'h83EA, "disp_e5");
    // No slot: colour holds whether the dot enable or the active flag is low
    DISP_PA = 6'd0; DISP_ACTIVE = 1'b1; DCLK_EN = 1'b0;
    tick();
    check_vec("hold_no_dclk", 32'(DISP_CLR), 32'h83EA);
    DISP_ACTIVE = 1'b0; DCLK_EN = 1'b1;
    tick();
    check_vec("hold_blank", 32'(DISP_CLR), 32'h83EA);
    DCLK_EN = 1'b0;

    // Test 2: read-back, including the dummy lane
    cpu_xfer(1'b0, 8'h14, 8'h00, rd, lat);
    check_vec("rd_r", 32'(rd), 32'h9F);
    check_vec("rd_r_lat", 32'(lat), 32'd4);
    cpu_xfer(1'b0, 8'h17, 8'h00, rd, lat);
    check_vec("rd_dummy", 32'(rd), 32'h00);
    check_vec("rd_dummy_lat", 32'(lat), 32'd4);
    cpu_xfer(1'b0, 8'h16, 8'h00, rd, lat);
    check_vec("rd_b", 32'(rd), 32'h0A);
    cpu_xfer(1'b1, 8'h17, 8'hFF, rd, lat);
    check_vec("wr_dummy_lat", 32'(lat), 32'd3);
    check_vec("rdata_held", 32'(cpu_bus.CPU_RDATA), 32'h0A);
    disp_dot(6'd5, 16'h83EA, "disp_after_dummy");

    // Test 3/4: write G=0x10 while every CLK is a display slot
    DCLK_EN = 1'b1; DISP_ACTIVE = 1'b1; DISP_PA = 6'd5;
    cpu_bus.CPU_REQ = 1'b1; cpu_bus.CPU_WE = 1'b1;
    cpu_bus.CPU_ADDR = 8'h15; cpu_bus.CPU_WDATA = 8'h10;
`ifdef T9990_PAL_STEAL_EN
    acks = 0; steals = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks   += int'(cpu_bus.CPU_ACK);
      steals += int'(STEAL);
    end
    check_vec("steal_early", 32'(steals), 32'd0);
    check_vec("steal_no_ack", 32'(acks), 32'd0);
    check_vec("steal_pre_clr", 32'(DISP_CLR), 32'h83EA);
    DISP_PA = 6'd9;
    tick();
    check_vec("steal_pulse", 32'(STEAL), 32'h1);
    check_vec("steal_clr_held", 32'(DISP_CLR), 32'h83EA);
    DISP_PA = 6'd5;
    tick();
    check_vec("steal_ack", 32'(cpu_bus.CPU_ACK), 32'h1);
    check_vec("steal_one_clk", 32'(STEAL), 32'h0);
    check_vec("steal_new_clr", 32'(DISP_CLR), 32'hC3EA);
    cpu_bus.CPU_REQ = 1'b0;
    DCLK_EN = 1'b0; DISP_ACTIVE = 1'b0;
    tick();
`else
    acks = 0; steals = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acks   += int'(cpu_bus.CPU_ACK);
      steals += int'(STEAL);
    end
    check_vec("blocked_no_ack", 32'(acks), 32'd0);
    check_vec("blocked_no_steal", 32'(steals), 32'd0);
    check_vec("blocked_clr", 32'(DISP_CLR), 32'h83EA);
    DISP_ACTIVE = 1'b0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
      if (cpu_bus.CPU_ACK) break;
    end
    check_vec("unblock_ack", 32'(cpu_bus.CPU_ACK), 32'h1);
    cpu_bus.CPU_REQ = 1'b0;
    DCLK_EN = 1'b0;
    tick();
`endif
    cpu_xfer(1'b0, 8'h14, 8'h00, rd, lat);
    check_vec("g_wr_r_kept", 32'(rd), 32'h9F);
    cpu_xfer(1'b0, 8'h16, 8'h00, rd, lat);
    check_vec("g_wr_b_kept", 32'(rd), 32'h0A);
    cpu_xfer(1'b0, 8'h15, 8'h00, rd, lat);
    check_vec("g_wr_g", 32'(rd), 32'h10);
    disp_dot(6'd5, 16'hC3EA, "disp_e5_g10");

    // Test 5: write in cycle N is visible to a display read in N+1
    cpu_bus.CPU_REQ = 1'b1; cpu_bus.CPU_WE = 1'b1;
    cpu_bus.CPU_ADDR = 8'h26; cpu_bus.CPU_WDATA = 8'h15;
    tick();                       // IDLE -> LATCH
    tick();                       // cycle N: granted write lands
    DCLK_EN = 1'b1; DISP_ACTIVE = 1'b1; DISP_PA = 6'd9;
    tick();                       // cycle N+1: display reads entry 9
    check_vec("hazard_ack", 32'(cpu_bus.CPU_ACK), 32'h1);
    check_vec("hazard_b", 32'(DISP_CLR[4:0]), 32'h15);
    cpu_bus.CPU_REQ = 1'b0;
    DCLK_EN = 1'b0; DISP_ACTIVE = 1'b0;
    tick();

    // Test 6: reset in the middle of an access
    cpu_bus.CPU_REQ = 1'b1; cpu_bus.CPU_WE = 1'b1;
    cpu_bus.CPU_ADDR = 8'h14; cpu_bus.CPU_WDATA = 8'h00;
    tick();
    tick();                       // now in ACCESS
    RESET_n = 1'b0;
    cpu_bus.CPU_REQ = 1'b0;
    #1;
    check_vec("mid_rst_disp_clr", 32'(DISP_CLR), 32'h0);
    check_vec("mid_rst_ack", 32'(cpu_bus.CPU_ACK), 32'h0);
    check_vec("mid_rst_rdata", 32'(cpu_bus.CPU_RDATA), 32'h0);
    check_vec("mid_rst_steal", 32'(STEAL), 32'h0);
    tick();
    RESET_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(cpu_bus.CPU_ACK);
    end
    check_vec("post_rst_no_ack", 32'(acks), 32'd0);
    check_vec("post_rst_clr", 32'(DISP_CLR), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
